// File: rtl/ps2_key_sequencer.sv
// Drains the PS/2 receive FIFO and turns scan-code set 2 byte sequences into
// single key events, with held-key tracking, typematic repeat handling and a press counter.
module ps2_key_sequencer #(
  parameter int unsigned SUPPRESS_REPEAT = 1,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         kbd_data,
  input  logic               kbd_ready,
  input  logic               kbd_overflow,
  output logic               kbd_next_n,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic               ev_repeat,
  output logic               held_valid,
  output logic [7:0]         held_code,
  output logic [COUNT_W-1:0] press_count,
  output logic               err,
  input  logic               err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE,
    S_EMIT
  } state_e;

  state_e               state_q, state_d;
  logic                 next_n_q, next_n_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [7:0]           ev_code_q, ev_code_d;
  logic                 ev_ext_q, ev_ext_d;
  logic                 ev_break_q, ev_break_d;
  logic                 ev_repeat_q, ev_repeat_d;
  logic                 held_valid_q, held_valid_d;
  logic [7:0]           held_code_q, held_code_d;
  logic                 held_ext_q, held_ext_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [2:0]           skip_q, skip_d;
  logic                 err_q, err_d;

  logic                 consume;
  logic                 set_err;
  logic                 do_make;
  logic                 do_brk;
  logic                 emit;
  logic                 emit_rpt;
  logic                 is_held;
  logic [7:0]           b_code;
  logic                 b_ext;

  assign consume = kbd_ready & ~next_n_q;

  always_comb begin
    state_d      = state_q;
    next_n_d     = 1'b1;
    ev_valid_d   = ev_valid_q;
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_break_d   = ev_break_q;
    ev_repeat_d  = ev_repeat_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    count_d      = count_q;
    skip_d       = skip_q;
    err_d        = err_q;
    set_err      = 1'b0;
    do_make      = 1'b0;
    do_brk       = 1'b0;
    emit         = 1'b0;
    emit_rpt     = 1'b0;
    b_code       = kbd_data;
    b_ext        = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    // A pending event completes first; overflow is only looked at outside EMIT.
    if (state_q == S_EMIT) begin
      if (ev_ready) begin
        ev_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    end else if (kbd_overflow) begin
      state_d      = S_IDLE;
      held_valid_d = 1'b0;
      skip_d       = '0;
      set_err      = 1'b1;
    end else begin
      next_n_d = ~(kbd_ready & next_n_q);
      if (consume) begin
        unique case (state_q)
          S_IDLE: begin
            case (kbd_data)
              8'hE0:                      state_d = S_EXT;
              8'hF0:                      state_d = S_BRK;
              8'hE1: begin
                state_d = S_PAUSE;
                skip_d  = 3'd7;
              end
              8'hFA, 8'hAA, 8'hEE, 8'hFE: state_d = S_IDLE;
              8'h00, 8'hFF:               set_err = 1'b1;
              default:                    do_make = 1'b1;
            endcase
          end
          S_EXT: begin
            case (kbd_data)
              8'hF0:   state_d = S_EXT_BRK;
              8'hE0:   state_d = S_EXT;
              default: begin
                do_make = 1'b1;
                b_ext   = 1'b1;
              end
            endcase
          end
          S_BRK, S_EXT_BRK: begin
            if (kbd_data == 8'hF0 || kbd_data == 8'hE0) begin
              set_err = 1'b1;
              state_d = S_IDLE;
            end else begin
              do_brk = 1'b1;
              b_ext  = (state_q == S_EXT_BRK);
            end
          end
          S_PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
              skip_d  = '0;
              do_make = 1'b1;
              b_code  = 8'hE1;
              b_ext   = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    is_held = held_valid_q && (held_code_q == b_code) && (held_ext_q == b_ext);

    if (do_make) begin
      if (is_held) begin
        if (SUPPRESS_REPEAT != 0) begin
          state_d = S_IDLE;
        end else begin
          emit     = 1'b1;
          emit_rpt = 1'b1;
        end
      end else begin
        held_valid_d = 1'b1;
        held_code_d  = b_code;
        held_ext_d   = b_ext;
        count_d      = count_q + COUNT_W'(1);
        emit         = 1'b1;
      end
    end

    if (do_brk) begin
      if (is_held) begin
        held_valid_d = 1'b0;
      end
      emit = 1'b1;
    end

    if (emit) begin
      ev_valid_d  = 1'b1;
      ev_code_d   = b_code;
      ev_ext_d    = b_ext;
      ev_break_d  = do_brk;
      ev_repeat_d = emit_rpt;
      state_d     = S_EMIT;
    end

    if (set_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_n_q     <= 1'b1;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= '0;
      ev_ext_q     <= 1'b0;
      ev_break_q   <= 1'b0;
      ev_repeat_q  <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      count_q      <= '0;
      skip_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_n_q     <= next_n_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_break_q   <= ev_break_d;
      ev_repeat_q  <= ev_repeat_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      count_q      <= count_d;
      skip_q       <= skip_d;
      err_q        <= err_d;
    end
  end

  assign kbd_next_n  = next_n_q;
  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_ext      = ev_ext_q;
  assign ev_break    = ev_break_q;
  assign ev_repeat   = ev_repeat_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign press_count = count_q;
  assign err         = err_q;

endmodule
